// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns PC and instruction register, fetches over req/gnt/rvalid.
// Optional opcode legality flag enabled by defining IFETCH_ILLEGAL_TRAP_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ins,
  output logic        ins_valid,
  input  logic        ins_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        ins_illegal,
  output logic [1:0]  dbg_state
);

  // Handshakes: a memory request transfers when mem_req && mem_gnt; exactly one
  // mem_rvalid follows each transfer. An instruction transfers when ins_valid && ins_ready.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        squash_q, squash_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ins_q;
  logic        load_ins;
  logic [31:0] target;

  assign target = redirect_pc & ~32'd3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_REQ;
      squash_q <= 1'b0;
      pc_q     <= RESET_PC;
      ins_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      squash_q <= squash_d;
      pc_q     <= pc_d;
      if (load_ins) ins_q <= mem_rdata;
    end
  end

  // Redirect outranks grant, response and consume in the same cycle.
  always_comb begin
    state_d  = state_q;
    squash_d = squash_q;
    pc_d     = pc_q;
    load_ins = 1'b0;
    case (state_q)
      S_REQ: begin
        if (redirect) pc_d = target;
        if (mem_gnt) begin
          state_d  = S_WAIT;
          squash_d = redirect;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d = target;
          if (mem_rvalid) begin
            state_d  = S_REQ;
            squash_d = 1'b0;
          end else begin
            squash_d = 1'b1;
          end
        end else if (mem_rvalid) begin
          squash_d = 1'b0;
          if (squash_q) begin
            state_d = S_REQ;
          end else begin
            load_ins = 1'b1;
            state_d  = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (ins_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    mem_req   = (state_q == S_REQ);
    ins_valid = (state_q == S_HOLD);
    mem_addr  = pc_q;
    pc        = pc_q;
    pc_plus4  = pc_q + 32'd4;
    ins       = ins_q;
    dbg_state = state_q;
  end

`ifdef IFETCH_ILLEGAL_TRAP_EN
  logic ill_q;
  logic rdata_legal;

  always_comb begin
    case (mem_rdata[31:26])
      6'b100000, 6'b100011, 6'b101011, 6'b001000,
      6'b000011, 6'b100110, 6'b001110, 6'b000100,
      6'b010000, 6'b000000, 6'b000010: rdata_legal = 1'b1;
      default:                         rdata_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ill_q <= 1'b0;
    end else if (load_ins) begin
      ill_q <= ~rdata_legal;
    end
  end

  assign ins_illegal = ill_q;
`else
  assign ins_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: table-driven fetches plus redirect/reset sequences,
// with fetched words tracked through an expected-instruction queue.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        ins_illegal;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    int          gnt_w;
    int          rv_w;
    logic [31:0] rdata;
    int          hold_w;
    logic        ill;
  } vec_t;

  vec_t vecs[6];

  instr_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .pc(pc), .pc_plus4(pc_plus4), .ins_illegal(ins_illegal),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected run to finish");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic eff_ill(input logic ill);
`ifdef IFETCH_ILLEGAL_TRAP_EN
    return ill;
`else
    return 1'b0 & ill;
`endif
  endfunction

  task automatic pop_exp(output logic [31:0] v);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL sb_pop: got empty queue expected an entry");
      v = 32'd0;
    end else begin
      v = exp_q.pop_front();
    end
  endtask

  // One complete fetch from REQ at addr through consume; ends back in REQ.
  task automatic do_fetch(input int gw, input int rw, input logic [31:0] data,
                          input int hw, input logic [31:0] addr, input logic ill);
    logic [31:0] exp_ins;
    exp_ins = 32'd0;
    for (int i = 0; i <= gw; i++) begin
      @(negedge clk);
      check1("req_high", mem_req, 1'b1);
      check32("req_addr", mem_addr, addr);
      mem_gnt = (i == gw);
    end
    for (int j = 0; j <= rw; j++) begin
      @(negedge clk);
      mem_gnt = 1'b0;
      check1("wait_req_low", mem_req, 1'b0);
      check1("wait_not_valid", ins_valid, 1'b0);
      mem_rvalid = (j == rw);
      mem_rdata  = (j == rw) ? data : $urandom;
      if (j == rw) exp_q.push_back(data);
    end
    for (int k = 0; k <= hw; k++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      check1("hold_valid", ins_valid, 1'b1);
      if (k == 0) pop_exp(exp_ins);
      check32("hold_ins", ins, exp_ins);
      check32("hold_pc", pc, addr);
      check1("hold_illegal", ins_illegal, eff_ill(ill));
      ins_ready = (k == hw);
    end
    @(negedge clk);
    ins_ready = 1'b0;
    check1("after_ready_valid", ins_valid, 1'b0);
    check1("after_ready_req", mem_req, 1'b1);
    check32("after_ready_addr", mem_addr, addr + 32'd4);
  endtask

  initial begin
    logic [31:0] addr;
    logic [31:0] tmp;

    vecs[0] = '{gnt_w: 0, rv_w: 0, rdata: 32'h8C22_0004, hold_w: 0, ill: 1'b0};
    vecs[1] = '{gnt_w: 3, rv_w: 0, rdata: 32'h2000_0000, hold_w: 0, ill: 1'b0};
    vecs[2] = '{gnt_w: 0, rv_w: 2, rdata: 32'hFC00_0000, hold_w: 5, ill: 1'b1};
    vecs[3] = '{gnt_w: 1, rv_w: 1, rdata: 32'h0C00_0010, hold_w: 1, ill: 1'b0};
    vecs[4] = '{gnt_w: 0, rv_w: 0, rdata: 32'h0400_0000, hold_w: 0, ill: 1'b1};
    vecs[5] = '{gnt_w: 2, rv_w: 3, rdata: 32'h9800_0123, hold_w: 2, ill: 1'b0};

    rst_n = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    ins_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    repeat (2) @(negedge clk);
    check1("rst_req", mem_req, 1'b1);
    check32("rst_addr", mem_addr, 32'h100);
    check32("rst_pc_plus4", pc_plus4, 32'h104);
    check1("rst_valid", ins_valid, 1'b0);
    check32("rst_ins", ins, 32'd0);
    check1("rst_illegal", ins_illegal, 1'b0);
    check32("rst_state", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;

    addr = 32'h100;
    foreach (vecs[v]) begin
      do_fetch(vecs[v].gnt_w, vecs[v].rv_w, vecs[v].rdata, vecs[v].hold_w, addr, vecs[v].ill);
      addr = addr + 32'd4;
    end
    for (int r = 0; r < 3; r++) begin
      do_fetch($urandom_range(0, 3), $urandom_range(0, 3), 32'h1000_0000 | 32'($urandom_range(0, 65535)),
               $urandom_range(0, 3), addr, 1'b0);
      addr = addr + 32'd4;
    end

    // Redirect while waiting; the stale response must be dropped.
    @(negedge clk);
    check32("a_req_addr", mem_addr, addr);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h2000;
    @(negedge clk);
    redirect = 1'b0;
    check32("a_pc_redir", pc, 32'h2000);
    check1("a_req_low", mem_req, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check1("a_req_again", mem_req, 1'b1);
    check32("a_addr", mem_addr, 32'h2000);
    check1("a_valid", ins_valid, 1'b0);
    check1("a_stale_not_loaded", ins !== 32'hDEAD_BEEF, 1'b1);
    do_fetch(0, 0, 32'h8000_0000, 0, 32'h2000, 1'b0);

    // Grant and redirect together in REQ: granted response is squashed.
    @(negedge clk);
    mem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h3003;
    @(negedge clk);
    mem_gnt = 1'b0; redirect = 1'b0;
    check1("b_req_low", mem_req, 1'b0);
    check32("b_pc", pc, 32'h3000);
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check1("b_req_again", mem_req, 1'b1);
    check32("b_addr", mem_addr, 32'h3000);
    check1("b_valid", ins_valid, 1'b0);
    do_fetch(0, 1, 32'h9C00_0000, 1, 32'h3000, 1'b1);

    // Redirect in HOLD alongside ins_ready: no +4, target forced aligned, then wrap.
    @(negedge clk);
    check32("c_addr", mem_addr, 32'h3004);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAC00_0008;
    exp_q.push_back(32'hAC00_0008);
    @(negedge clk);
    mem_rvalid = 1'b0;
    check1("c_valid", ins_valid, 1'b1);
    pop_exp(tmp);
    check32("c_ins", ins, tmp);
    ins_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    @(negedge clk);
    ins_ready = 1'b0; redirect = 1'b0;
    check1("c_valid_drop", ins_valid, 1'b0);
    check1("c_req", mem_req, 1'b1);
    check32("c_addr_redir", mem_addr, 32'hFFFF_FFFC);
    check32("c_pc_plus4_wrap", pc_plus4, 32'd0);
    do_fetch(0, 0, 32'h3800_0000, 0, 32'hFFFF_FFFC, 1'b0);

    // Reset pulse while waiting for a response.
    @(negedge clk);
    check32("d_addr", mem_addr, 32'd0);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check1("d_req", mem_req, 1'b1);
    check32("d_pc", pc, 32'h100);
    check1("d_valid", ins_valid, 1'b0);
    check32("d_ins", ins, 32'd0);
    check1("d_illegal", ins_illegal, 1'b0);
    check32("d_state", {30'd0, dbg_state}, 32'd0);
    do_fetch(0, 0, 32'h8C22_0004, 0, 32'h100, 1'b0);

    check32("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the multicycle core. It owns the PC and the instruction register, and issues word reads to instruction memory over a request/grant/response handshake. It presents each fetched 32-bit instruction word to the control decoder and execute stage with a valid/ready handshake. It applies PC redirects from jump, jump-register and branch resolution, squashing any fetch already in flight.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- clk  in  1: the single clock; all state updates on its rising edge.
- rst_n  in  1: reset, synchronous, active-low.
- mem_req  out  1: fetch request to instruction memory.
- mem_addr  out  32: word address of the request; always equals pc.
- mem_gnt  in  1: memory accepts the request this cycle; only meaningful while mem_req=1.
- mem_rvalid  in  1: read data valid, at least one cycle after the grant; exactly one per grant.
- mem_rdata  in  32: instruction word, sampled when mem_rvalid=1.
- ins  out  32: instruction register contents; ins[31:26] is the opcode.
- ins_valid  out  1: ins holds an unconsumed instruction.
- ins_ready  in  1: consumer accepts ins this cycle.
- redirect  in  1: one-cycle pulse that replaces the next PC.
- redirect_pc  in  32: target PC; bits [1:0] are forced to 0 on capture.
- pc  out  32: address of the instruction in ins, or of the pending fetch.
- pc_plus4  out  32: pc + 4, with 32-bit wraparound; used as the jal link value.
- ins_illegal  out  1: the opcode in ins is unsupported; qualified by ins_valid.

## Operation
- Three FSM states: REQ, WAIT and HOLD. A squash flag accompanies WAIT.
- REQ: mem_req=1 and mem_addr=pc.
  - mem_gnt=1 → WAIT.
  - Otherwise stay in REQ; mem_addr is held stable.
- WAIT: mem_req=0.
  - On mem_rvalid with squash=0: ins<=mem_rdata, then → HOLD.
  - On mem_rvalid with squash=1: discard the data, clear squash, then → REQ.
- HOLD: ins_valid=1.
  - On ins_ready=1: pc<=pc+4, then → REQ.
  - Otherwise hold; ins and pc stay stable.
- Redirect rules (redirect has priority over every other event in the same cycle):
  - In REQ: pc<=redirect_pc and stay in REQ. If mem_gnt is also 1 that cycle, go to WAIT with squash=1 instead.
  - In WAIT: pc<=redirect_pc and squash<=1. If mem_rvalid is also 1 that cycle, discard the data and go straight to REQ.
  - In HOLD: pc<=redirect_pc, ins_valid drops next cycle, → REQ. This applies whether or not ins_ready=1; no pc+4 is applied.
- mem_rvalid arriving in REQ or HOLD is ignored. This is a protocol error by memory.
- pc_plus4 is combinational from pc.
- Arithmetic is 32-bit unsigned; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values (one cycle after rst_n=0 is sampled):
  - state=REQ, pc=RESET_PC, squash=0, ins=0.
  - ins_valid=0, ins_illegal=0.
  - mem_req=1 from the first cycle after reset.
- Reset mid-operation aborts everything. Memory shares rst_n, so no response from before reset is expected.
- Best case, with the grant in cycle N and mem_rvalid in N+1: ins_valid=1 in N+2.
- With ins_ready=1 in cycle M, mem_req=1 again in M+1.
- Full throughput is one instruction per 3 cycles with a zero-wait memory.
- Redirect in cycle R:
  - mem_addr=redirect_pc in R+1 if R is in REQ or HOLD.
  - If R is in WAIT, mem_addr=redirect_pc in the cycle after the squashed response.
- ins_valid and ins never change while ins_valid=1 and ins_ready=0, unless redirect=1.

## Configuration
- IFETCH_ILLEGAL_TRAP_EN defined:
  - ins_illegal is registered alongside ins.
  - It is 1 unless mem_rdata[31:26] is one of: 100000 (and), 100011 (lw), 101011 (sw), 001000 (jr), 000011 (jal), 100110 (nor), 001110 (nori), 000100 (not), 010000 (bleu), 000000 (rolv), 000010 (rorv).
  - Fetch behaviour is unchanged; the consumer decides on the trap.
- IFETCH_ILLEGAL_TRAP_EN undefined: ins_illegal is tied to 0 and no decode logic is present.

## Test plan
- Reset with RESET_PC=0x100 and a zero-wait memory returning 0x8C220004 → mem_addr 0x100, then ins=0x8C220004 with ins_valid, then mem_addr 0x104 one cycle after ins_ready.
- Grant withheld for 3 cycles → mem_req and mem_addr held at pc for 3 cycles; exactly one request is granted.
- HOLD with ins_ready=0 for 5 cycles → ins, pc and ins_valid stable; pc advances by 4 only after ins_ready.
- Redirect to 0x2000 while in WAIT, with stale data 0xDEADBEEF → 0xDEADBEEF never appears on ins; next mem_addr=0x2000.
- Simultaneous mem_gnt and redirect=1 to 0x3003 in REQ → the granted response is dropped; next fetch is at 0x3000.
- With IFETCH_ILLEGAL_TRAP_EN defined: rdata 0xFC000000 → ins_illegal=1; rdata 0x0C000010 → ins_illegal=0. Without the macro: ins_illegal=0 in both cases.
- rst_n low for one cycle while in WAIT → next cycle is REQ with pc=RESET_PC and ins_valid=0.
